entrada_teclas: RTL and testbench

Input conditioning stage between the board push-buttons and the ship block. Synchronises and debounces the four active-low keys, then converts them into the `keysout[3:0]` strobes the ship consumes: rate-limited move pulses, a one-shot fire pulse with a reload cooldown, and a pause-toggle request. All outputs are registered and single-cycle, so the ship advances one pixel per move tick rather than one per clock.

---
 rtl/entrada_teclas.sv | 106 ++++++++++
 tb/tb_entrada_teclas.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/entrada_teclas.sv
// rtl/entrada_teclas.sv - push-button sync/debounce and ship key strobes
// Produces rate-limited move pulses, cooldown-gated fire and pause-toggle pulses.
module entrada_teclas #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int MOVE_DIV        = 250000,
   parameter int FIRE_COOLDOWN   = 25000000
) (
   input  logic       CLOCK_50,
   input  logic       resetNave,
   input  logic [3:0] KEY,
   input  logic       pausa,
   output logic [3:0] keysout,
   output logic [3:0] teclas_estaveis
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int MW = $clog2(MOVE_DIV);
   localparam int CW = $clog2(FIRE_COOLDOWN);
   localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [MW-1:0] DIV_MAX  = MW'(MOVE_DIV - 1);
   localparam logic [CW-1:0] COOL_MAX = CW'(FIRE_COOLDOWN - 1);

   typedef enum logic {PRONTO = 1'b0, RECARGA = 1'b1} estado_t;

   logic [3:0]    r_sync1, r_sync2, r_est, r_est_q, r_keys;
   logic [DW-1:0] r_db_cnt [4];
   logic [MW-1:0] r_div;
   logic [CW-1:0] r_cool, w_cool_prox;
   estado_t       r_estado, w_estado_prox;
   logic          w_tick, w_fire, w_rise_fire;

   // Inverted before the first flop so a cleared synchroniser reads "released".
   always_ff @(posedge CLOCK_50 or posedge resetNave) begin
      if (resetNave) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= ~KEY;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge resetNave) begin
      if (resetNave) begin
         r_est <= '0;
         for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_est[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_MAX) begin
               r_est[i]    <= ~r_est[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_tick      = (r_div == DIV_MAX);
   assign w_rise_fire = r_est[1] & ~r_est_q[1];

   always_comb begin
      w_estado_prox = r_estado;
      w_cool_prox   = r_cool;
      w_fire        = 1'b0;
      case (r_estado)
         PRONTO: begin
            if (w_rise_fire && !pausa) begin
               w_fire        = 1'b1;
               w_cool_prox   = COOL_MAX;
               w_estado_prox = RECARGA;
            end
         end
         RECARGA: begin
            // Cooldown keeps running while paused; edges here are discarded.
            if (r_cool == '0) w_estado_prox = PRONTO;
            else              w_cool_prox   = r_cool - 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge resetNave) begin
      if (resetNave) begin
         r_div    <= '0;
         r_cool   <= '0;
         r_estado <= PRONTO;
         r_est_q  <= '0;
         r_keys   <= '0;
      end else begin
         r_div     <= w_tick ? '0 : r_div + 1'b1;
         r_cool    <= w_cool_prox;
         r_estado  <= w_estado_prox;
         r_est_q   <= r_est;
         r_keys[0] <= w_tick & r_est[0] & ~r_est[2] & ~pausa;
         r_keys[1] <= w_fire;
         r_keys[2] <= w_tick & r_est[2] & ~r_est[0] & ~pausa;
         r_keys[3] <= r_est[3] & ~r_est_q[3];
      end
   end

   assign keysout         = r_keys;
   assign teclas_estaveis = r_est;

endmodule

// File: tb/tb_entrada_teclas.sv
// tb/tb_entrada_teclas.sv - self-checking bench for entrada_teclas
// Reference model works on sample windows and pulse timestamps, not counters.
module tb_entrada_teclas;

   localparam int DB = 4;
   localparam int MV = 8;
   localparam int FC = 16;

   logic       CLOCK_50 = 1'b0;
   logic       resetNave;
   logic       pausa;
   logic [3:0] KEY;
   logic [3:0] keysout;
   logic [3:0] teclas_estaveis;

   always #5 CLOCK_50 = ~CLOCK_50;

   entrada_teclas #(
      .DEBOUNCE_CYCLES(DB),
      .MOVE_DIV(MV),
      .FIRE_COOLDOWN(FC)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .resetNave(resetNave),
      .KEY(KEY),
      .pausa(pausa),
      .keysout(keysout),
      .teclas_estaveis(teclas_estaveis)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cnt_p [4];

   logic [3:0] m_hist [5];
   logic [3:0] m_est, m_est_prev, m_keys;
   int         m_edge, m_last_fire;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int j = 0; j < 5; j++) m_hist[j] = '0;
      m_est       = '0;
      m_est_prev  = '0;
      m_keys      = '0;
      m_edge      = 0;
      m_last_fire = -1000;
   endfunction

   // One rising clock edge: samples reaching the debouncer lag raw input by two
   // edges, and a level is accepted once DB consecutive samples disagree with it.
   function automatic void model_edge();
      logic [3:0] e_b, q_b, nxt;
      logic       tick, all_diff;
      int         k;
      k    = m_edge + 1;
      e_b  = m_est;
      q_b  = m_est_prev;
      tick = ((m_edge % MV) == MV - 1);
      m_keys[0] = tick & e_b[0] & ~e_b[2] & ~pausa;
      m_keys[2] = tick & e_b[2] & ~e_b[0] & ~pausa;
      m_keys[3] = e_b[3] & ~q_b[3];
      m_keys[1] = 1'b0;
      if (e_b[1] && !q_b[1] && !pausa && (k - m_last_fire) >= FC + 1) begin
         m_keys[1]   = 1'b1;
         m_last_fire = k;
      end
      nxt = e_b;
      for (int i = 0; i < 4; i++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= DB; j++) if (m_hist[j][i] == e_b[i]) all_diff = 1'b0;
         if (all_diff) nxt[i] = ~e_b[i];
      end
      for (int j = 4; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0]  = ~KEY;
      m_est_prev = e_b;
      m_est      = nxt;
      m_edge     = k;
   endfunction

   task automatic step();
      model_edge();
      @(posedge CLOCK_50);
      #1;
      chk("keysout", keysout, m_keys);
      chk("teclas_estaveis", teclas_estaveis, m_est);
      for (int i = 0; i < 4; i++) if (keysout[i]) cnt_p[i]++;
   endtask

   task automatic run(input logic [3:0] k, input logic p, input int n);
      KEY   = k;
      pausa = p;
      for (int c = 0; c < n; c++) step();
   endtask

   task automatic clr_cnt();
      for (int i = 0; i < 4; i++) cnt_p[i] = 0;
   endtask

   task automatic do_reset();
      resetNave = 1'b1;
      #1;
      chk("rst_keysout", keysout, 4'h0);
      chk("rst_est", teclas_estaveis, 4'h0);
      model_reset();
      @(posedge CLOCK_50);
      #1;
      resetNave = 1'b0;
   endtask

   initial begin
      int n;
      resetNave = 1'b1;
      KEY       = 4'hF;
      pausa     = 1'b0;
      clr_cnt();
      model_reset();
      #3;
      do_reset();

      // Bounce shorter than the debounce window is rejected.
      run(4'hF, 0, 10);
      clr_cnt();
      run(4'hE, 0, 3);
      run(4'hF, 0, 1);
      run(4'hE, 0, 3);
      run(4'hF, 0, 10);
      chk("bounce_est0", teclas_estaveis[0], 1'b0);

      KEY = 4'hE;
      n = 0;
      while (n < 20 && !teclas_estaveis[0]) begin
         step();
         n++;
      end
      chk("db_latency", n, 6);

      // Move rate: any 96 consecutive cycles hold exactly 12 ticks.
      clr_cnt();
      run(4'hE, 0, 96);
      chk("move_right_cnt", cnt_p[0], 12);
      chk("move_left_cnt", cnt_p[2], 0);
      run(4'hA, 0, 10);
      clr_cnt();
      run(4'hA, 0, 48);
      chk("both_right_cnt", cnt_p[0], 0);
      chk("both_left_cnt", cnt_p[2], 0);
      run(4'hF, 0, 20);

      // Second press inside the cooldown is dropped, a later one fires.
      clr_cnt();
      run(4'hD, 0, 8);
      run(4'hF, 0, 6);
      run(4'hD, 0, 8);
      chk("fire_in_cooldown", cnt_p[1], 1);
      run(4'hF, 0, 8);
      run(4'hD, 0, 8);
      chk("fire_after_cooldown", cnt_p[1], 2);

      run(4'hF, 0, 30);
      clr_cnt();
      run(4'hD, 0, 200);
      chk("fire_hold_no_repeat", cnt_p[1], 1);

      // Pausa gates fire and move but not the pause toggle.
      run(4'hF, 1, 30);
      clr_cnt();
      run(4'hC, 1, 40);
      chk("paused_fire", cnt_p[1], 0);
      chk("paused_move", cnt_p[0], 0);
      run(4'h4, 1, 30);
      chk("paused_toggle", cnt_p[3], 1);
      run(4'hF, 0, 30);

      // Reset while in cooldown with fire still held.
      run(4'hD, 0, 10);
      do_reset();
      clr_cnt();
      n = 0;
      while (n < 30 && !keysout[1]) begin
         step();
         n++;
      end
      chk("rst_fire_latency", n, 7);
      run(4'hD, 0, 40);
      chk("rst_fire_count", cnt_p[1], 1);

      // Random key / pausa / reset traffic against the model.
      for (int s = 0; s < 150; s++) begin
         if ($urandom_range(0, 29) == 0) do_reset();
         run(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
             int'($urandom_range(1, 20)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
